store_writer: RTL



---
 rtl/store_writer_pkg.sv | 32 +++
 rtl/store_writer.sv | 136 +++++++++++++
 2 files changed

// File: rtl/store_writer_pkg.sv
// store_writer_pkg: shared constants for the byte-serial store path.
//   - size encodings SZ_BYTE/SZ_HALF/SZ_WORD (3 is treated as word)
//   - FSM state encodings ST_IDLE/ST_WAIT_GNT/ST_WRITE/ST_DONE
//   - IO_HI (addr[17:16] value marking IO space), TRUE/FALSE, DATA_W (bus byte width)
//   - last_idx(): index of the final byte for a given size
`timescale 1ns/1ps
package store_writer_pkg;
  localparam logic       TRUE   = 1'b1;
  localparam logic       FALSE  = 1'b0;
  localparam int         DATA_W = 8;
  localparam logic [1:0] IO_HI  = 2'b11;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_GNT = 2'd1,
    ST_WRITE    = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  // nbytes-1 for a size code; size 3 folds into word
  function automatic logic [1:0] last_idx(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: return 2'd0;
      SZ_HALF: return 2'd1;
      default: return 2'd3;
    endcase
  endfunction
endpackage

// File: rtl/store_writer.sv
// store_writer: takes one store (addr/data/size) from the store/load buffer,
// requests the shared 8-bit RAM/IO bus, and writes 1/2/4 bytes little-endian,
// one byte per cycle. IO-space bytes stall while the UART buffer is full.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   rdy               global ready; low freezes everything and blocks mem_wr
//   req_valid/ready   request handshake (ready only in IDLE)
//   req_addr/data/size  store request
//   done              one-cycle completion pulse (stretched by rdy low)
//   mem_req/mem_gnt   bus request / grant
//   io_buffer_full    UART buffer full
//   mem_a/mem_dout/mem_wr  byte write port
//   err               misaligned-store flag (only with STORE_WRITER_ALIGN_CHECK_EN)
//
// Optional feature macro: STORE_WRITER_ALIGN_CHECK_EN -- rejects misaligned
// half/word stores without touching the bus and flags them on err.
`timescale 1ns/1ps
module store_writer
  import store_writer_pkg::*;
#(
  parameter int         ADDR_W = 32,
  parameter logic [1:0] IO_HI  = store_writer_pkg::IO_HI
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  input  logic [1:0]        req_size,
  output logic              req_ready,
  output logic              done,
  output logic              mem_req,
  input  logic              mem_gnt,
  input  logic              io_buffer_full,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_dout,
  output logic              mem_wr
`ifdef STORE_WRITER_ALIGN_CHECK_EN
  ,
  output logic              err
`endif
);

  state_t            state;
  logic [1:0]        idx;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;

  logic [ADDR_W-1:0] cur_a;
  logic [DATA_W-1:0] cur_byte;
  logic              in_write;
  logic              io_hold;
  logic              last_byte;
  logic              misaligned;

  assign cur_a     = addr_q + ADDR_W'(idx);   // wraps mod 2^ADDR_W
  assign in_write  = (state == ST_WRITE);
  assign io_hold   = io_buffer_full && (cur_a[17:16] == IO_HI);
  assign last_byte = (idx == last_idx(size_q));

  always_comb begin
    cur_byte = data_q[7:0];
    case (idx)
      2'd1:    cur_byte = data_q[15:8];
      2'd2:    cur_byte = data_q[23:16];
      2'd3:    cur_byte = data_q[31:24];
      default: cur_byte = data_q[7:0];
    endcase
  end

`ifdef STORE_WRITER_ALIGN_CHECK_EN
  logic err_q;
  // size 3 is a word, so bit 1 of the size code selects the word check
  assign misaligned = ((req_size == SZ_HALF) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));
  assign err = (state == ST_DONE) && err_q;
`else
  assign misaligned = FALSE;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      idx    <= 2'd0;
      size_q <= SZ_BYTE;
      addr_q <= '0;
      data_q <= '0;
`ifdef STORE_WRITER_ALIGN_CHECK_EN
      err_q  <= 1'b0;
`endif
    end else if (rdy) begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            addr_q <= req_addr;
            data_q <= req_data;
            size_q <= (req_size == 2'd3) ? SZ_WORD : req_size;
            idx    <= 2'd0;
`ifdef STORE_WRITER_ALIGN_CHECK_EN
            err_q  <= misaligned;
`endif
            // rejected stores skip the bus and report straight away
            state  <= misaligned ? ST_DONE : ST_WAIT_GNT;
          end
        end
        ST_WAIT_GNT: if (mem_gnt) state <= ST_WRITE;
        ST_WRITE: begin
          if (!io_hold) begin
            idx <= idx + 2'd1;
            if (last_byte) state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
`ifdef STORE_WRITER_ALIGN_CHECK_EN
          err_q <= 1'b0;
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Outputs decode the registered state; inside WRITE the address/byte stay
  // presented during a hold (idx frozen), and are zero everywhere else.
  assign req_ready = (state == ST_IDLE) && !rst;
  assign mem_req   = (state == ST_WAIT_GNT) || in_write;
  assign done      = (state == ST_DONE);
  assign mem_wr    = in_write && rdy && !io_hold;
  assign mem_a     = in_write ? cur_a : '0;
  assign mem_dout  = in_write ? cur_byte : '0;

endmodule
